// File: rtl/rv32i_exec_ctrl_dmem.sv
// rtl/rv32i_exec_ctrl_dmem.sv - RV32I control decoder, ALU with flags, and word data memory.
module rv32i_exec_ctrl_dmem #(
  parameter int          DEPTH      = 1024,
  parameter logic [31:0] VIDEO_BASE = 32'h0000_8000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        nop,
  input  logic [16:0] cu_info,
  output logic        we_reg,
  output logic        we_mem,
  output logic [2:0]  rf_sel,
  output logic [3:0]  alu_sel,
  output logic [1:0]  op2_sel,
  output logic        is_load,
  output logic        is_signed,
  output logic [1:0]  word_length,
  input  logic [31:0] op1,
  input  logic [31:0] op2,
  input  logic        alu_signed,
  input  logic [3:0]  alu_sel_in,
  output logic [31:0] alu_out,
  output logic        z,
  output logic        n,
  input  logic [31:0] mem_addr,
  input  logic [31:0] mem_din,
  input  logic        mem_we,
  output logic [31:0] mem_dout
);

  localparam int AW = $clog2(DEPTH);

  localparam logic [3:0] ALU_ADD  = 4'b0000;
  localparam logic [3:0] ALU_SUB  = 4'b0001;
  localparam logic [3:0] ALU_SLL  = 4'b0010;
  localparam logic [3:0] ALU_SLT  = 4'b0011;
  localparam logic [3:0] ALU_XOR  = 4'b0100;
  localparam logic [3:0] ALU_SRL  = 4'b0101;
  localparam logic [3:0] ALU_SRA  = 4'b0110;
  localparam logic [3:0] ALU_OR   = 4'b0111;
  localparam logic [3:0] ALU_AND  = 4'b1000;
  localparam logic [3:0] ALU_PASS = 4'b1001;

  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_I      = 7'b0010011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;

  logic [6:0] opcode;
  logic [2:0] funct3;
  logic       alt;
  logic       unused_funct7;

  assign opcode        = cu_info[6:0];
  assign funct3        = cu_info[9:7];
  assign alt           = cu_info[15];
  assign unused_funct7 = ^{cu_info[16], cu_info[14:10]};

  // R-type lets funct7[5] pick SUB; I-type never does, since ADDI has no SUBI twin.
  function automatic logic [3:0] alu_map(input logic [2:0] f3, input logic alt_bit,
                                         input logic allow_sub);
    case (f3)
      3'b000:  alu_map = (alt_bit && allow_sub) ? ALU_SUB : ALU_ADD;
      3'b001:  alu_map = ALU_SLL;
      3'b010:  alu_map = ALU_SLT;
      3'b011:  alu_map = ALU_SLT;
      3'b100:  alu_map = ALU_XOR;
      3'b101:  alu_map = alt_bit ? ALU_SRA : ALU_SRL;
      3'b110:  alu_map = ALU_OR;
      default: alu_map = ALU_AND;
    endcase
  endfunction

  always_comb begin
    we_reg      = 1'b0;
    we_mem      = 1'b0;
    is_load     = 1'b0;
    rf_sel      = 3'b000;
    alu_sel     = ALU_ADD;
    op2_sel     = 2'b00;
    is_signed   = 1'b1;
    word_length = 2'b10;
    if (!nop && !rst) begin
      case (opcode)
        OP_R: begin
          we_reg    = 1'b1;
          op2_sel   = 2'b11;
          alu_sel   = alu_map(funct3, alt, 1'b1);
          is_signed = (funct3 != 3'b011);
        end
        OP_I: begin
          we_reg    = 1'b1;
          alu_sel   = alu_map(funct3, alt, 1'b0);
          is_signed = (funct3 != 3'b011);
        end
        OP_LOAD: begin
          we_reg      = 1'b1;
          rf_sel      = 3'b001;
          is_load     = 1'b1;
          word_length = funct3[1:0];
          is_signed   = !funct3[2];
        end
        OP_STORE: begin
          we_mem      = 1'b1;
          op2_sel     = 2'b01;
          word_length = funct3[1:0];
        end
        OP_BRANCH: begin
          op2_sel   = 2'b11;
          alu_sel   = ALU_SUB;
          is_signed = !funct3[1];
        end
        OP_LUI: begin
          we_reg = 1'b1;
          rf_sel = 3'b010;
        end
        OP_AUIPC: begin
          we_reg = 1'b1;
          rf_sel = 3'b100;
        end
        OP_JAL: begin
          we_reg  = 1'b1;
          rf_sel  = 3'b011;
          op2_sel = 2'b10;
        end
        OP_JALR: begin
          we_reg = 1'b1;
          rf_sel = 3'b011;
        end
        default: ;
      endcase
    end
  end

  logic [4:0] shamt;
  assign shamt = op2[4:0];
  assign n     = alu_signed ? ($signed(op1) < $signed(op2)) : (op1 < op2);

  always_comb begin
    alu_out = 32'd0;
    case (alu_sel_in)
      ALU_ADD:  alu_out = op1 + op2;
      ALU_SUB:  alu_out = op1 - op2;
      ALU_SLL:  alu_out = op1 << shamt;
      ALU_SLT:  alu_out = {31'd0, n};
      ALU_XOR:  alu_out = op1 ^ op2;
      ALU_SRL:  alu_out = op1 >> shamt;
      ALU_SRA:  alu_out = $unsigned($signed(op1) >>> shamt);
      ALU_OR:   alu_out = op1 | op2;
      ALU_AND:  alu_out = op1 & op2;
      ALU_PASS: alu_out = op2;
      default:  alu_out = 32'd0;
    endcase
  end

  assign z = (alu_out == 32'd0);

  logic [31:0]   mem_q [DEPTH];
  logic [AW-1:0] idx;
  logic          wr_en;

  assign idx      = mem_addr[AW+1:2];
  assign wr_en    = mem_we && (mem_addr < VIDEO_BASE);
  assign mem_dout = mem_q[idx];

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= 32'd0;
    end else if (wr_en) begin
      mem_q[idx] <= mem_din;
    end
  end

endmodule

// File: tb/tb_rv32i_exec_ctrl_dmem.sv
// tb/tb_rv32i_exec_ctrl_dmem.sv - directed scoreboard bench for rv32i_exec_ctrl_dmem.
module tb_rv32i_exec_ctrl_dmem;

  logic        clk = 1'b0;
  logic        rst, nop;
  logic [16:0] cu_info;
  logic        we_reg, we_mem, is_load, is_signed;
  logic [2:0]  rf_sel;
  logic [3:0]  alu_sel;
  logic [1:0]  op2_sel, word_length;
  logic [31:0] op1, op2, alu_out;
  logic        alu_signed, z, n;
  logic [3:0]  alu_sel_in;
  logic [31:0] mem_addr, mem_din, mem_dout;
  logic        mem_we;

  int errors = 0;
  int checks = 0;

  typedef struct {
    string       tag;
    logic [63:0] exp;
  } sb_t;
  sb_t sb_q[$];

  always #5 clk = ~clk;

  rv32i_exec_ctrl_dmem dut (
    .clk(clk), .rst(rst), .nop(nop), .cu_info(cu_info),
    .we_reg(we_reg), .we_mem(we_mem), .rf_sel(rf_sel), .alu_sel(alu_sel),
    .op2_sel(op2_sel), .is_load(is_load), .is_signed(is_signed),
    .word_length(word_length), .op1(op1), .op2(op2), .alu_signed(alu_signed),
    .alu_sel_in(alu_sel_in), .alu_out(alu_out), .z(z), .n(n),
    .mem_addr(mem_addr), .mem_din(mem_din), .mem_we(mem_we), .mem_dout(mem_dout)
  );

  function automatic logic [63:0] dv(input logic wr, input logic wm, input logic [2:0] rf,
                                     input logic [3:0] al, input logic [1:0] o2,
                                     input logic ld, input logic sg, input logic [1:0] wl);
    dv = {49'd0, wr, wm, rf, al, o2, ld, sg, wl};
  endfunction

  function automatic logic [63:0] av(input logic zf, input logic nf, input logic [31:0] r);
    av = {30'd0, zf, nf, r};
  endfunction

  task automatic push(input string tag, input logic [63:0] exp);
    sb_t e;
    e.tag = tag;
    e.exp = exp;
    sb_q.push_back(e);
  endtask

  task automatic pop_check(input logic [63:0] obs);
    sb_t e;
    checks++;
    if (sb_q.size() == 0) begin
      errors++;
      $error("FAIL scoreboard_empty obs=%h", obs);
    end else begin
      e = sb_q.pop_front();
      assert (obs === e.exp)
      else begin
        errors++;
        $error("FAIL %s obs=%h exp=%h", e.tag, obs, e.exp);
      end
    end
  endtask

  function automatic logic [63:0] dec_obs();
    dec_obs = dv(we_reg, we_mem, rf_sel, alu_sel, op2_sel, is_load, is_signed, word_length);
  endfunction

  task automatic dec_step(input string tag, input logic nop_v, input logic [6:0] f7,
                          input logic [2:0] f3, input logic [6:0] opc, input logic [63:0] exp);
    @(negedge clk);
    nop     = nop_v;
    cu_info = {f7, f3, opc};
    push(tag, exp);
    #2;
    pop_check(dec_obs());
  endtask

  task automatic alu_step(input string tag, input logic [3:0] sel, input logic [31:0] a,
                          input logic [31:0] b, input logic sgn, input logic [63:0] exp);
    @(negedge clk);
    alu_sel_in = sel;
    op1        = a;
    op2        = b;
    alu_signed = sgn;
    push(tag, exp);
    #2;
    pop_check(av(z, n, alu_out));
  endtask

  task automatic mem_read(input string tag, input logic [31:0] addr, input logic [31:0] exp);
    @(negedge clk);
    mem_we   = 1'b0;
    mem_addr = addr;
    push(tag, {32'd0, exp});
    #2;
    pop_check({32'd0, mem_dout});
  endtask

  // Drives a store, checks the old word is still visible before the edge.
  task automatic mem_write(input string tag, input logic [31:0] addr, input logic [31:0] data,
                           input logic [31:0] old);
    @(negedge clk);
    mem_addr = addr;
    mem_din  = data;
    mem_we   = 1'b1;
    push(tag, {32'd0, old});
    #2;
    pop_check({32'd0, mem_dout});
    @(posedge clk);
    #1;
    mem_we = 1'b0;
  endtask

  localparam logic [63:0] NOP_V = 64'h6;

  initial begin
    rst = 1'b1; nop = 1'b0; cu_info = {7'b0100000, 3'b000, 7'b0110011};
    op1 = '0; op2 = '0; alu_signed = 1'b0; alu_sel_in = 4'd0;
    mem_addr = 32'h10; mem_din = '0; mem_we = 1'b0;
    repeat (2) @(posedge clk);
    #2;
    push("reset_decoder", NOP_V);
    pop_check(dec_obs());
    push("reset_mem", 64'd0);
    pop_check({32'd0, mem_dout});
    @(negedge clk);
    rst = 1'b0;

    dec_step("sub",     1'b0, 7'b0100000, 3'b000, 7'b0110011, dv(1, 0, 3'b000, 4'b0001, 2'b11, 0, 1, 2'b10));
    dec_step("sub_nop", 1'b1, 7'b0100000, 3'b000, 7'b0110011, NOP_V);
    dec_step("lbu",     1'b0, 7'b0000000, 3'b100, 7'b0000011, dv(1, 0, 3'b001, 4'b0000, 2'b00, 1, 0, 2'b00));
    dec_step("sh",      1'b0, 7'b0000000, 3'b001, 7'b0100011, dv(0, 1, 3'b000, 4'b0000, 2'b01, 0, 1, 2'b01));
    dec_step("jalr",    1'b0, 7'b0000000, 3'b000, 7'b1100111, dv(1, 0, 3'b011, 4'b0000, 2'b00, 0, 1, 2'b10));
    dec_step("undef",   1'b0, 7'b0000000, 3'b000, 7'b1111111, NOP_V);
    dec_step("sltiu",   1'b0, 7'b0000000, 3'b011, 7'b0010011, dv(1, 0, 3'b000, 4'b0011, 2'b00, 0, 0, 2'b10));
    dec_step("srai",    1'b0, 7'b0100000, 3'b101, 7'b0010011, dv(1, 0, 3'b000, 4'b0110, 2'b00, 0, 1, 2'b10));
    dec_step("addi_f7", 1'b0, 7'b0100000, 3'b000, 7'b0010011, dv(1, 0, 3'b000, 4'b0000, 2'b00, 0, 1, 2'b10));
    dec_step("bltu",    1'b0, 7'b0000000, 3'b110, 7'b1100011, dv(0, 0, 3'b000, 4'b0001, 2'b11, 0, 0, 2'b10));
    dec_step("blt",     1'b0, 7'b0000000, 3'b100, 7'b1100011, dv(0, 0, 3'b000, 4'b0001, 2'b11, 0, 1, 2'b10));
    dec_step("lui",     1'b0, 7'b0000000, 3'b000, 7'b0110111, dv(1, 0, 3'b010, 4'b0000, 2'b00, 0, 1, 2'b10));
    dec_step("auipc",   1'b0, 7'b0000000, 3'b000, 7'b0010111, dv(1, 0, 3'b100, 4'b0000, 2'b00, 0, 1, 2'b10));
    dec_step("jal",     1'b0, 7'b0000000, 3'b000, 7'b1101111, dv(1, 0, 3'b011, 4'b0000, 2'b10, 0, 1, 2'b10));
    dec_step("sltu_r",  1'b0, 7'b0000000, 3'b011, 7'b0110011, dv(1, 0, 3'b000, 4'b0011, 2'b11, 0, 0, 2'b10));

    alu_step("sub_s",   4'b0001, 32'hFFFF_FFFF, 32'h1, 1'b1, av(0, 1, 32'hFFFF_FFFE));
    alu_step("sub_u",   4'b0001, 32'hFFFF_FFFF, 32'h1, 1'b0, av(0, 0, 32'hFFFF_FFFE));
    alu_step("add_wrap",4'b0000, 32'hFFFF_FFFF, 32'h1, 1'b0, av(1, 0, 32'h0));
    alu_step("sra",     4'b0110, 32'h8000_0000, 32'h4, 1'b1, av(0, 1, 32'hF800_0000));
    alu_step("srl",     4'b0101, 32'h8000_0000, 32'h4, 1'b0, av(0, 0, 32'h0800_0000));
    alu_step("sll_amt", 4'b0010, 32'h8000_0000, 32'h21, 1'b0, av(1, 0, 32'h0));
    alu_step("slt_s",   4'b0011, 32'hFFFF_FFFF, 32'h1, 1'b1, av(0, 1, 32'h1));
    alu_step("slt_u",   4'b0011, 32'hFFFF_FFFF, 32'h1, 1'b0, av(1, 0, 32'h0));
    alu_step("xor",     4'b0100, 32'hF0F0_1234, 32'h0FF0_4321, 1'b0, av(0, 0, 32'hFF00_5115));
    alu_step("or",      4'b0111, 32'hF000_0000, 32'h0000_000F, 1'b0, av(0, 0, 32'hF000_000F));
    alu_step("and",     4'b1000, 32'hF0F0_F0F0, 32'h0FF0_0FF0, 1'b0, av(0, 0, 32'h00F0_00F0));
    alu_step("pass",    4'b1001, 32'h5, 32'h1234, 1'b0, av(0, 1, 32'h1234));
    alu_step("invalid", 4'b1111, 32'h5, 32'h1234, 1'b0, av(1, 1, 32'h0));

    mem_write("wr_old",  32'h10, 32'hDEAD_BEEF, 32'h0);
    mem_read ("rd_10",   32'h10, 32'hDEAD_BEEF);
    mem_write("wr_vid",  32'h8010, 32'h1234_5678, 32'hDEAD_BEEF);
    mem_read ("vid_blk", 32'h10, 32'hDEAD_BEEF);
    mem_read ("wrap",    32'h1010, 32'hDEAD_BEEF);
    mem_write("wr_20",   32'h20, 32'hCAFE_F00D, 32'h0);
    mem_read ("rd_20",   32'h20, 32'hCAFE_F00D);

    @(negedge clk);
    rst      = 1'b1;
    mem_we   = 1'b1;
    mem_addr = 32'h24;
    mem_din  = 32'h5555_AAAA;
    @(posedge clk);
    #1;
    rst    = 1'b0;
    mem_we = 1'b0;
    mem_read("rst_10", 32'h10, 32'h0);
    mem_read("rst_20", 32'h20, 32'h0);
    mem_read("rst_blk_wr", 32'h24, 32'h0);

    if (sb_q.size() != 0) begin
      checks++;
      errors++;
      $error("FAIL scoreboard_leftover obs=%0d exp=0", sb_q.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
